// File: rtl/uart_rx_if.sv
// Host-side byte interface of the UART receiver: payload, valid/ready
// handshake and the per-frame error strobes.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  // Receiver side: produces bytes and error strobes, observes ready.
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output frame_err,
    output parity_err,
    output overrun_err
  );

  // Consumer side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  frame_err,
    input  parity_err,
    input  overrun_err
  );

endinterface : uart_rx_if

// File: rtl/uart_rx.sv
// UART receiver with 16x (OVERSAMPLE) tick-based mid-bit sampling,
// valid/ready byte output, framing and overrun error strobes.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN;
// without it the PARITY state is absent and parity_err is tied low.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int unsigned S_W = $clog2(OVERSAMPLE);
  localparam int unsigned B_W = $clog2(DATA_BITS + 1);

  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_FULL = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_BITS - 1);

  // Reject configurations the counters and sampling points cannot support.
  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 ||
      (OVERSAMPLE % 2) != 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state_q, state_nxt;
  logic                 rx_meta, rx_s;
  logic [S_W-1:0]       s_cnt_q, s_cnt_nxt;
  logic [B_W-1:0]       b_cnt_q, b_cnt_nxt;
  logic [DATA_BITS-1:0] shreg_q, shreg_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 valid_q, valid_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 oerr_q, oerr_nxt;
  logic                 s_mid;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic pend_q, pend_nxt;
  logic perr_q, perr_nxt;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Sampling point of a full bit period (mid-bit once START has aligned us).
  assign s_mid = tick && (s_cnt_q == S_FULL);

  // Next-state, counter, shift register and output logic.
  always_comb begin
    state_nxt = state_q;
    s_cnt_nxt = s_cnt_q;
    b_cnt_nxt = b_cnt_q;
    shreg_nxt = shreg_q;
    data_nxt  = data_q;
    valid_nxt = valid_q && !bus.rx_ready;
    ferr_nxt  = 1'b0;
    oerr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pend_nxt  = pend_q;
    perr_nxt  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          s_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
          pend_nxt  = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (tick) begin
          if (s_cnt_q == S_HALF) begin
            s_cnt_nxt = '0;
            if (!rx_s) begin
              state_nxt = ST_DATA;
              b_cnt_nxt = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            s_cnt_nxt = s_cnt_q + S_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_mid) begin
          s_cnt_nxt = '0;
          b_cnt_nxt = b_cnt_q + B_W'(1);
          shreg_nxt = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (b_cnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end else if (tick) begin
          s_cnt_nxt = s_cnt_q + S_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (s_mid) begin
          s_cnt_nxt = '0;
          pend_nxt  = rx_s ^ (^shreg_q) ^ PAR_ODD;
          state_nxt = ST_STOP;
        end else if (tick) begin
          s_cnt_nxt = s_cnt_q + S_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (s_mid) begin
          s_cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shreg_q;
            valid_nxt = 1'b1;
            oerr_nxt  = valid_q && !bus.rx_ready;
`ifdef UART_RX_PARITY_EN
            perr_nxt  = pend_q;
`endif
            state_nxt = ST_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_BREAK;
          end
        end else if (tick) begin
          s_cnt_nxt = s_cnt_q + S_W'(1);
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      b_cnt_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      s_cnt_q <= s_cnt_nxt;
      b_cnt_q <= b_cnt_nxt;
      shreg_q <= shreg_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      oerr_q  <= oerr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity pending flag and its commit-time strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      perr_q <= perr_nxt;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = oerr_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven on rx, the
// expected bytes go into a scoreboard queue and are popped on each handshake.
module tb_uart_rx;

  localparam int unsigned DB       = 8;
  localparam int unsigned OS       = 16;
  localparam int unsigned PODD     = 0;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLKS = OS * TICK_DIV;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       rx    = 1'b1;
  logic [1:0] tdiv  = 2'd0;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .PARITY_ODD(PODD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .rx   (rx),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  int  valid_cnt       = 0;
  int  ferr_cnt        = 0;
  int  perr_cnt        = 0;
  int  oerr_cnt        = 0;
  int  perr_with_valid = 0;
  int  valid_drop      = 0;
  bit  watch_valid     = 1'b0;

  always #5 clk = ~clk;

  // One-cycle tick every TICK_DIV clocks.
  always @(posedge clk) begin
    tdiv <= tdiv + 2'd1;
    tick <= (tdiv == 2'(TICK_DIV - 1));
  end

  // Output monitor: scoreboard pops on handshake, error pulses are counted.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_err)   ferr_cnt++;
      if (bus.parity_err)  perr_cnt++;
      if (bus.overrun_err) oerr_cnt++;
      if (watch_valid && !bus.rx_valid) valid_drop++;
      if (bus.rx_valid && bus.rx_ready) begin
        valid_cnt++;
        if (bus.parity_err) perr_with_valid++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got rx_data=%h, required no byte", bus.rx_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (bus.rx_data !== sb_exp) begin
            bad++;
            $display("FAIL sb_data: got %h, required %h", bus.rx_data, sb_exp);
          end
        end
      end
    end
  end

  // Hard stop if the run ever stalls.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ 1'(PODD) ^ par_flip;
    wait_clks(BIT_CLKS);
`endif
    rx = stop;
    wait_clks(BIT_CLKS);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clks(1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.rx_ready = 1'b1;
    reset = 1'b1;
    wait_clks(4);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h, required 00", bus.rx_data); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b, required 0", bus.frame_err); end
    total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL rst_perr: got %b, required 0", bus.parity_err); end
    total++; if (bus.overrun_err !== 1'b0) begin bad++; $display("FAIL rst_oerr: got %b, required 0", bus.overrun_err); end
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic test_basic();
    int v0, e0;
    v0 = valid_cnt;
    e0 = ferr_cnt + perr_cnt + oerr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    drain();
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL basic_valid_count: got %0d, required 1", valid_cnt - v0); end
    total++; if (ferr_cnt + perr_cnt + oerr_cnt - e0 !== 0) begin bad++; $display("FAIL basic_errs: got %0d, required 0", ferr_cnt + perr_cnt + oerr_cnt - e0); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt;
    e0 = ferr_cnt + perr_cnt + oerr_cnt;
    rx = 1'b0;
    wait_clks(3 * TICK_DIV);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d, required 0", valid_cnt - v0); end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    drain();
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL glitch_next_frame: got %0d, required 1", valid_cnt - v0); end
    total++; if (ferr_cnt + perr_cnt + oerr_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_errs: got %0d, required 0", ferr_cnt + perr_cnt + oerr_cnt - e0); end
  endtask

  task automatic test_break();
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_clks(20 * BIT_CLKS);
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL break_ferr: got %0d, required 1", ferr_cnt - f0); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL break_valid: got %0d, required 0", valid_cnt - v0); end
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    drain();
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL break_recover: got %0d, required 1", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL break_ferr_total: got %0d, required 1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = oerr_cnt;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold_valid: got %b, required 1", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h11) begin bad++; $display("FAIL ovr_first_data: got %h, required 11", bus.rx_data); end
    watch_valid = 1'b1;
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    watch_valid = 1'b0;
    total++; if (valid_drop !== 0) begin bad++; $display("FAIL ovr_valid_drop: got %0d, required 0", valid_drop); end
    total++; if (oerr_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d, required 1", oerr_cnt - o0); end
    total++; if (bus.rx_data !== 8'h22) begin bad++; $display("FAIL ovr_final_data: got %h, required 22", bus.rx_data); end
    bus.rx_ready = 1'b1;
    drain();
    wait_clks(2);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_consumed: got %b, required 0", bus.rx_valid); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0, pv0;
    p0  = perr_cnt;
    pv0 = perr_with_valid;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(BIT_CLKS);
    drain();
    total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL par_pulses: got %0d, required 1", perr_cnt - p0); end
    total++; if (perr_with_valid - pv0 !== 1) begin bad++; $display("FAIL par_with_valid: got %0d, required 1", perr_with_valid - pv0); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] d;
    int v0;
    d = 8'hC3;
    bus.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    total++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A) begin bad++; $display("FAIL rmid_pre: got valid=%b data=%h, required valid=1 data=5a", bus.rx_valid, bus.rx_data); end
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    rx = d[4];
    wait_clks(BIT_CLKS / 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b, required 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h, required 00", bus.rx_data); end
    total++; if ({bus.frame_err, bus.parity_err, bus.overrun_err} !== 3'b000) begin bad++; $display("FAIL rmid_errs: got %b, required 000", {bus.frame_err, bus.parity_err, bus.overrun_err}); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx    = 1'b1;
    wait_clks(12 * BIT_CLKS);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_gap_valid: got %b, required 0", bus.rx_valid); end
    bus.rx_ready = 1'b1;
    v0 = valid_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    drain();
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL rmid_after: got %0d, required 1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
# uart_rx

UART receiver that converts the serial `rx` line into parallel bytes, using the 16x oversampling `tick` produced by the baud tick generator in the same clock domain. It sits between the pad-side serial input and the host-side byte consumer. It provides a valid/ready output handshake, framing error and overrun error reporting, and optional parity checking.

## Interface
- `DATA_BITS`, 8: payload bits per frame; legal range 5..9.
- `OVERSAMPLE`, 16: `tick` pulses per bit period; must be even and at least 8.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Used only when parity is compiled in.

- `clk` in 1: system clock.
- `reset` in 1: synchronous reset, active-high.
- `tick` in 1: one-cycle strobe at OVERSAMPLE × baud rate.
- `rx` in 1: asynchronous serial line; idles high.
- `rx_data` out DATA_BITS: received payload, LSB first on the wire.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts the byte.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse when parity mismatches. Held at 0 when parity is compiled out.
- `overrun_err` out 1: one-cycle pulse when a new byte lands while `rx_valid` is already high.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
  - All decisions below use the synchronized value, `rx_s`.
- Counters:
  - `s_cnt` counts ticks, width $clog2(OVERSAMPLE).
  - `b_cnt` counts bits, width $clog2(DATA_BITS+1).
  - Both counters change only on cycles where `tick` = 1.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: `rx_s` = 0 → START, with `s_cnt` = 0. This transition does not wait for `tick`.
  - START: on each tick, `s_cnt` increments. When `s_cnt` = OVERSAMPLE/2−1 on a tick:
    - `rx_s` = 0 → DATA, with `s_cnt` = 0 and `b_cnt` = 0.
    - `rx_s` = 1 → IDLE. This is a glitch: no error flag and no output change.
  - DATA: when `s_cnt` = OVERSAMPLE−1 on a tick:
    - Shift `rx_s` into the MSB of the shift register (right shift).
    - Set `s_cnt` = 0 and increment `b_cnt`.
    - After DATA_BITS samples → PARITY (parity compiled in) or STOP (parity compiled out).
  - PARITY: at mid-bit, compare `rx_s` against the parity computed over the shift register, then → STOP. A mismatch sets an internal pending flag.
  - STOP: at mid-bit:
    - `rx_s` = 1 → commit the frame, then → IDLE.
    - `rx_s` = 0 → pulse `frame_err`, drop the byte (`rx_data` and `rx_valid` unchanged), then → BREAK.
  - BREAK: wait for `rx_s` = 1, then → IDLE. This prevents a held-low line (break condition) from retriggering START.
- Commit, which happens only on a good stop bit:
  - Load `rx_data` from the shift register and set `rx_valid` = 1.
  - If `rx_valid` was already 1 and `rx_ready` = 0 in that cycle, pulse `overrun_err`. The new byte overwrites the old one.
  - If parity is pending, pulse `parity_err` in the commit cycle. The byte is still delivered.
- Handshake:
  - `rx_valid` clears in the cycle after `rx_valid && rx_ready`.
  - Simultaneous commit and consume: the commit wins. `rx_valid` stays 1 with the new data, and no overrun is flagged.
- Reset:
  - State → IDLE; counters → 0; shift register → 0.
  - `rx_data` = 0; `rx_valid` = 0; all error outputs = 0.
  - Reset mid-frame discards the partial byte. The remaining bits of that frame are received as garbage or glitches, which is acceptable.

## Timing
- Synchronizer latency: 2 `clk` cycles from a change on `rx` to `rx_s`.
- Start-bit qualification: OVERSAMPLE/2 ticks after the falling edge is detected.
- Each data, parity and stop bit is sampled OVERSAMPLE ticks after the previous sample, i.e. at mid-bit.
- `rx_valid`, `frame_err`, `parity_err` and `overrun_err` are registered. Each asserts in the cycle after the stop-bit sampling tick.
- Nominal latency from the start edge to `rx_valid`: (DATA_BITS + 1.5 + P) bit periods + 3 `clk` cycles, where P = 1 with parity compiled in, otherwise 0.
- No combinational path from `rx_ready` to any output.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists; frames carry one parity bit after the data bits.
  - `parity_err` is functional; PARITY_ODD selects the parity sense.
- Not defined:
  - The PARITY state and its logic are removed; DATA → STOP directly.
  - `parity_err` is tied to 0, and the port is kept.

## Test plan
- Byte 0xA5, 8N1, `tick` every 4 `clk` cycles, `rx_ready` = 1 → one `rx_valid` pulse with `rx_data` = 0xA5; all error outputs stay 0.
- Low glitch on `rx` lasting 3 ticks while idle → no `rx_valid`, state returns to IDLE, and a following 0x3C frame is received correctly.
- Frame 0x55 with stop bit driven 0, then `rx` held low for 20 bit periods → one `frame_err` pulse, no `rx_valid`, no second `frame_err`. A following 0x0F frame is received after `rx` returns high.
- `rx_ready` = 0 while frames 0x11 then 0x22 are sent → `rx_valid` = 1 throughout, `overrun_err` pulses once, final `rx_data` = 0x22.
- With `UART_RX_PARITY_EN`, PARITY_ODD = 0, byte 0x07 sent with parity bit 0 (wrong; expected 1) → `rx_data` = 0x07, `rx_valid` = 1, `parity_err` pulses in the same cycle.
- `reset` asserted during data bit 4 of a frame → all outputs return to 0 the next cycle. After an idle gap, a clean 0xC3 frame is received correctly.
